// File: rtl/gpio_sr_pkg.sv
// Shared types and helpers for the GPIO shift-register serializer.
package gpio_sr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_LATCH    = 3'd4
    } state_e;

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpio_sr_tick.sv
// Reloadable down-counter; tick_o marks the last cycle of a CLK_DIV-long phase.
module gpio_sr_tick
    import gpio_sr_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reload_i,
    output logic tick_o
);

    localparam int W = cnt_width(CLK_DIV);
    localparam logic [W-1:0] RELOAD = W'(CLK_DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: reload on phase entry, otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (reload_i) begin
            cnt_d = RELOAD;
        end else if (cnt_q != {W{1'b0}}) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/gpio_sr_serializer.sv
// Drives a 74HC595-style shift/latch register from the GPIO output value,
// resending on every change or on request; outputs stay disabled until the first latch.
module gpio_sr_serializer
    import gpio_sr_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] gpio_in,
    input  logic              force_refresh,
    output logic              sr_data,
    output logic              sr_clk,
    output logic              sr_latch,
    output logic              sr_oe_n,
    output logic              busy,
    output logic              done
);

    localparam int BC_W = cnt_width(DATA_W);
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_W - 1);

    state_e            state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] last_sent_q;
    logic [BC_W-1:0]   bit_cnt_q;
    logic              pending_q;
    logic              sr_data_q;
    logic              sr_clk_q;
    logic              sr_latch_q;
    logic              sr_oe_n_q;
    logic              busy_q;
    logic              done_q;

    logic              timed_s;
    logic              reload_s;
    logic              tick_s;
    logic              start_s;
    logic [DATA_W-1:0] shifted_s;

    function automatic logic out_bit(input logic [DATA_W-1:0] v);
        return MSB_FIRST ? v[DATA_W-1] : v[0];
    endfunction

    // Phase timing, start detection and the next shift-register image.
    always_comb begin
        timed_s   = (state_q == ST_SHIFT_LO) || (state_q == ST_SHIFT_HI) ||
                    (state_q == ST_LATCH);
        reload_s  = !timed_s || tick_s;
        start_s   = (gpio_in != last_sent_q) || pending_q || force_refresh;
        shifted_s = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
    end

    gpio_sr_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .reload_i (reload_s),
        .tick_o   (tick_s)
    );

    // Transfer FSM; pad outputs are set on the transition into each state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shreg_q     <= {DATA_W{1'b0}};
            last_sent_q <= {DATA_W{1'b0}};
            bit_cnt_q   <= {BC_W{1'b0}};
            pending_q   <= 1'b1;
            sr_data_q   <= 1'b0;
            sr_clk_q    <= 1'b0;
            sr_latch_q  <= 1'b0;
            sr_oe_n_q   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            pending_q <= pending_q | force_refresh;
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    shreg_q     <= gpio_in;
                    last_sent_q <= gpio_in;
                    bit_cnt_q   <= BIT_LAST;
                    // A refresh arriving in this very cycle must survive the clear.
                    pending_q   <= force_refresh;
                    sr_data_q   <= out_bit(gpio_in);
                    sr_clk_q    <= 1'b0;
                    state_q     <= ST_SHIFT_LO;
                end
                ST_SHIFT_LO: begin
                    if (tick_s) begin
                        sr_clk_q <= 1'b1;
                        state_q  <= ST_SHIFT_HI;
                    end
                end
                ST_SHIFT_HI: begin
                    if (tick_s) begin
                        sr_clk_q <= 1'b0;
                        if (bit_cnt_q == {BC_W{1'b0}}) begin
                            sr_latch_q <= 1'b1;
                            state_q    <= ST_LATCH;
                        end else begin
                            shreg_q   <= shifted_s;
                            bit_cnt_q <= bit_cnt_q - BC_W'(1);
                            sr_data_q <= out_bit(shifted_s);
                            state_q   <= ST_SHIFT_LO;
                        end
                    end
                end
                ST_LATCH: begin
                    if (tick_s) begin
                        sr_latch_q <= 1'b0;
                        sr_oe_n_q  <= 1'b0;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    sr_clk_q   <= 1'b0;
                    sr_latch_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign sr_data  = sr_data_q;
    assign sr_clk   = sr_clk_q;
    assign sr_latch = sr_latch_q;
    assign sr_oe_n  = sr_oe_n_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
